// File: rtl/npc_pkg.sv
// Shared definitions for the load/store unit.
// Holds the LSU FSM state encoding, the access size codes, the default WAIT
// timeout and a helper that classifies an access as misaligned or illegal.
package npc_pkg;

    typedef enum logic [1:0] {
        LSU_IDLE  = 2'd0,
        LSU_ISSUE = 2'd1,
        LSU_WAIT  = 2'd2,
        LSU_RESP  = 2'd3
    } lsu_state_e;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;
    localparam logic [1:0] SIZE_RSVD = 2'd3;

    localparam int unsigned LSU_TIMEOUT_DEFAULT = 255;

    // True when the access must be rejected without touching memory:
    // reserved size code, or a half/word not naturally aligned.
    function automatic logic lsu_bad_access(input logic [1:0] size,
                                            input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = addr_lo[0];
            SIZE_WORD: bad = |addr_lo;
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for the load/store unit (purely combinational).
// Ports:
//   size_i     access size code (byte/half/word)
//   addr_lo_i  byte offset within the word
//   wen_i      1 = store; the write mask is forced to 0 for loads
//   unsigned_i 1 = zero-extend loads, 0 = sign-extend
//   wdata_i    right-aligned store data
//   rdata_i    full memory word returned for a load
//   wmask_o    byte-lane write mask, upper nibble always 0
//   wdata_o    store data shifted onto its byte lanes
//   rdata_o    load data shifted down, truncated to size and extended
module lsu_align
    import npc_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        wen_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [7:0]  wmask_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [4:0]  shamt;
    logic [3:0]  base_mask;
    logic [3:0]  lane_mask;
    logic [31:0] rdata_sh;

    assign shamt = {addr_lo_i, 3'b000};

    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path through the case statements can leave it holding (a latch).
    always_comb begin
        base_mask = 4'h0;
        case (size_i)
            SIZE_BYTE: base_mask = 4'h1;
            SIZE_HALF: base_mask = 4'h3;
            SIZE_WORD: base_mask = 4'hF;
            default:   base_mask = 4'h0;
        endcase
    end

    // Only naturally aligned accesses reach memory, so the shifted mask always
    // fits in the low nibble; truncating to 4 bits is intentional.
    assign lane_mask = base_mask << addr_lo_i;
    assign wmask_o   = wen_i ? {4'b0000, lane_mask} : 8'h00;
    assign wdata_o   = wdata_i << shamt;
    assign rdata_sh  = rdata_i >> shamt;

    always_comb begin
        rdata_o = rdata_sh;
        case (size_i)
            SIZE_BYTE: rdata_o = unsigned_i ? {24'h000000, rdata_sh[7:0]}
                                            : {{24{rdata_sh[7]}}, rdata_sh[7:0]};
            SIZE_HALF: rdata_o = unsigned_i ? {16'h0000, rdata_sh[15:0]}
                                            : {{16{rdata_sh[15]}}, rdata_sh[15:0]};
            default:   rdata_o = rdata_sh;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one access at a time from upstream,
// rejects misaligned or illegal-size accesses without touching memory, issues
// a single memory request, waits (bounded by TIMEOUT cycles) for the
// completion strobe and returns the aligned/extended result.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   req_*             upstream request (valid/ready handshake)
//   resp_*            upstream response (valid/ready handshake)
//   mem_valid/ready   memory request handshake
//   mem_*addr/wdata/wmask/wen  word-aligned request fields
//   mem_rvalid/rdata  memory completion strobe and read word
module lsu_ctrl
    import npc_pkg::*;
#(
    parameter int unsigned TIMEOUT = LSU_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_valid,
    output logic        mem_wen,
    input  logic        mem_ready,
    output logic [31:0] mem_raddr,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    // Counter runs 0..TIMEOUT-1 across the WAIT cycles.
    localparam int unsigned      CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wen_q, wen_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [1:0]       size_q, size_d;
    logic             unsigned_q, unsigned_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;

    logic [7:0]       align_wmask;
    logic [31:0]      align_wdata;
    logic [31:0]      align_rdata;

    lsu_align u_align (
        .size_i     (size_q),
        .addr_lo_i  (addr_q[1:0]),
        .wen_i      (wen_q),
        .unsigned_i (unsigned_q),
        .wdata_i    (wdata_q),
        .rdata_i    (mem_rdata),
        .wmask_o    (align_wmask),
        .wdata_o    (align_wdata),
        .rdata_o    (align_rdata)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wen_d      = wen_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        rdata_d    = rdata_q;
        err_d      = err_q;

        case (state_q)
            LSU_IDLE: begin
                if (req_valid) begin
                    wen_d      = req_wen;
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    size_d     = req_size;
                    unsigned_d = req_unsigned;
                    rdata_d    = 32'h0;
                    if (lsu_bad_access(req_size, req_addr[1:0])) begin
                        err_d   = 1'b1;
                        state_d = LSU_RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = LSU_ISSUE;
                    end
                end
            end
            LSU_ISSUE: begin
                if (mem_ready) begin
                    cnt_d   = '0;
                    state_d = LSU_WAIT;
                end
            end
            LSU_WAIT: begin
                // Completion wins over a timeout landing on the same cycle.
                if (mem_rvalid) begin
                    rdata_d = wen_q ? 32'h0 : align_rdata;
                    err_d   = 1'b0;
                    state_d = LSU_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = 32'h0;
                    err_d   = 1'b1;
                    state_d = LSU_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LSU_RESP: begin
                if (resp_ready) begin
                    state_d = LSU_IDLE;
                end
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= LSU_IDLE;
            cnt_q      <= '0;
            wen_q      <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            size_q     <= SIZE_BYTE;
            unsigned_q <= 1'b0;
            rdata_q    <= 32'h0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wen_q      <= wen_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    // req_ready is gated by rst_n so it is low for the whole reset window,
    // not just after the first reset edge.
    assign req_ready  = rst_n && (state_q == LSU_IDLE);
    assign resp_valid = (state_q == LSU_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    assign mem_valid  = (state_q == LSU_ISSUE);
    assign mem_wen    = wen_q;
    assign mem_raddr  = {addr_q[31:2], 2'b00};
    assign mem_waddr  = {addr_q[31:2], 2'b00};
    assign mem_wmask  = align_wmask;
    assign mem_wdata  = align_wdata;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed cases with literal expectations
// followed by randomized transactions checked against a behavioural model.
module tb_lsu_ctrl;

    localparam int TB_TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_wen, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_valid, mem_wen, mem_ready, mem_rvalid;
    logic [31:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wen      (req_wen),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_valid    (mem_valid),
        .mem_wen      (mem_wen),
        .mem_ready    (mem_ready),
        .mem_raddr    (mem_raddr),
        .mem_waddr    (mem_waddr),
        .mem_wdata    (mem_wdata),
        .mem_wmask    (mem_wmask),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata)
    );

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] rdata;
        int          d_ready;   // cycles mem_ready held low
        int          r_at;      // WAIT cycle (1-based) carrying mem_rvalid
        int          q_resp;    // cycles resp_ready held low
        logic        e_access;
        logic [31:0] e_word;
        logic [7:0]  e_mask;
        logic [31:0] e_wdata;
        logic [31:0] e_rdata;
        logic        e_err;
        int          e_wait;
    } txn_t;

    txn_t cur;
    logic txn_active  = 1'b0;
    int   mem_cycles  = 0;
    int   resp_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic m_bad(input logic [1:0] size, input logic [31:0] addr);
        int nbytes;
        if (size == 2'd3) return 1'b1;
        nbytes = 1 << size;
        return (addr % nbytes) != 0;
    endfunction

    function automatic logic [7:0] m_mask(input logic wen, input logic [1:0] size, input logic [31:0] addr);
        int nbytes;
        if (!wen || size == 2'd3) return 8'h00;
        nbytes = 1 << size;
        return 8'(((1 << nbytes) - 1) << (addr % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] wdata, input logic [31:0] addr);
        longint unsigned w;
        w = 64'(wdata) << (8 * (addr % 4));
        return w[31:0];
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rdata, input logic [31:0] addr,
                                           input logic [1:0] size, input logic uns);
        longint unsigned v, keep;
        int nbits;
        nbits = 8 << size;
        keep  = (64'd1 << nbits) - 1;
        v     = (64'(rdata) >> (8 * (addr % 4))) & keep;
        if (!uns && ((v >> (nbits - 1)) & 64'd1) == 64'd1) v = v | ~keep;
        return v[31:0];
    endfunction

    function automatic txn_t mk(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [1:0] size, input logic uns, input logic [31:0] rdata,
                                input int d_ready, input int r_at, input int q_resp);
        txn_t t;
        logic timed_out;
        t.wen = wen; t.addr = addr; t.wdata = wdata; t.size = size; t.uns = uns;
        t.rdata = rdata; t.d_ready = d_ready; t.r_at = r_at; t.q_resp = q_resp;
        t.e_access = !m_bad(size, addr);
        t.e_word   = addr & ~32'h3;
        t.e_mask   = m_mask(wen, size, addr);
        t.e_wdata  = m_wdata(wdata, addr);
        timed_out  = (r_at > TB_TIMEOUT);
        t.e_wait   = timed_out ? TB_TIMEOUT : r_at;
        t.e_err    = !t.e_access || timed_out;
        t.e_rdata  = (t.e_err || wen) ? 32'h0 : m_load(rdata, addr, size, uns);
        return t;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (txn_active) begin
            check("req_ready_busy", {31'b0, req_ready}, 32'd0);
            if (mem_valid) begin
                mem_cycles++;
                check("mem_access_expected", {31'b0, mem_valid}, {31'b0, cur.e_access});
                check("mem_raddr", mem_raddr, cur.e_word);
                check("mem_waddr", mem_waddr, cur.e_word);
                check("mem_wen",   {31'b0, mem_wen}, {31'b0, cur.wen});
                check("mem_wmask", {24'b0, mem_wmask}, {24'b0, cur.e_mask});
                check("mem_wdata", mem_wdata, cur.e_wdata);
            end
            if (resp_valid) begin
                resp_cycles++;
                check("resp_rdata", resp_rdata, cur.e_rdata);
                check("resp_err",   {31'b0, resp_err}, {31'b0, cur.e_err});
            end
        end
    end

    // ---------------- driver ----------------
    // Entered and left at a negedge with the DUT idle.
    task automatic run_txn(input txn_t t);
        int waited;
        cur          = t;
        req_valid    = 1'b1;
        req_wen      = t.wen;
        req_addr     = t.addr;
        req_wdata    = t.wdata;
        req_size     = t.size;
        req_unsigned = t.uns;
        mem_ready    = 1'b0;
        mem_rvalid   = 1'($urandom_range(0, 1));
        resp_ready   = 1'b0;
        @(posedge clk);
        #1;
        txn_active  = 1'b1;
        mem_cycles  = 0;
        resp_cycles = 0;
        @(negedge clk);
        // Scramble the request fields to prove the DUT holds captured copies.
        req_valid    = 1'b0;
        req_wen      = 1'($urandom_range(0, 1));
        req_addr     = $urandom;
        req_wdata    = $urandom;
        req_size     = 2'($urandom_range(0, 3));
        req_unsigned = 1'($urandom_range(0, 1));
        if (t.e_access) begin
            for (int k = 0; k < t.d_ready; k++) begin
                mem_ready  = 1'b0;
                mem_rvalid = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            mem_ready  = 1'b1;
            mem_rvalid = 1'($urandom_range(0, 1));
            @(negedge clk);
            mem_ready = 1'b0;
            mem_rdata = t.rdata;
            waited    = -1;
            for (int k = 1; k <= TB_TIMEOUT + 4; k++) begin
                if (resp_valid) begin
                    waited = k - 1;
                    break;
                end
                mem_rvalid = (k == t.r_at);
                @(negedge clk);
            end
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            check("wait_cycles", 32'(waited), 32'(t.e_wait));
        end
        check("resp_valid_up", {31'b0, resp_valid}, 32'd1);
        for (int k = 0; k < t.q_resp; k++) begin
            resp_ready = 1'b0;
            mem_rvalid = 1'($urandom_range(0, 1));
            req_valid  = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        resp_ready = 1'b1;
        req_valid  = 1'b1;   // must not be taken in the consuming cycle
        @(posedge clk);
        #1;
        txn_active = 1'b0;
        @(negedge clk);
        resp_ready = 1'b0;
        check("idle_req_ready",  {31'b0, req_ready},  32'd1);
        check("idle_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("idle_mem_valid",  {31'b0, mem_valid},  32'd0);
        req_valid  = 1'b0;
        mem_rvalid = 1'b0;
        check("mem_valid_cycles", 32'(mem_cycles), t.e_access ? 32'(t.d_ready + 1) : 32'd0);
        check("resp_cycles", 32'(resp_cycles), 32'(t.q_resp + 1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"},  {31'b0, req_ready},  32'd0);
        check({tag, "_resp_valid"}, {31'b0, resp_valid}, 32'd0);
        check({tag, "_resp_rdata"}, resp_rdata, 32'd0);
        check({tag, "_resp_err"},   {31'b0, resp_err},   32'd0);
        check({tag, "_mem_valid"},  {31'b0, mem_valid},  32'd0);
        check({tag, "_mem_wen"},    {31'b0, mem_wen},    32'd0);
        check({tag, "_mem_wmask"},  {24'b0, mem_wmask},  32'd0);
        check({tag, "_mem_raddr"},  mem_raddr, 32'd0);
        check({tag, "_mem_waddr"},  mem_waddr, 32'd0);
        check({tag, "_mem_wdata"},  mem_wdata, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t t;
        rst_n = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_addr = 32'h0;
        req_wdata = 32'h0; req_size = 2'd0; req_unsigned = 1'b0;
        resp_ready = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;

        // Model pins against hand-computed values.
        check("pin_model_sbyte", m_load(32'h80123456, 32'h80000003, 2'd0, 1'b0), 32'hFFFFFF80);
        check("pin_model_ubyte", m_load(32'h80123456, 32'h80000003, 2'd0, 1'b1), 32'h00000080);
        check("pin_model_mask",  {24'b0, m_mask(1'b1, 2'd1, 32'h80000002)}, 32'h0000000C);
        check("pin_model_wdata", m_wdata(32'h0000ABCD, 32'h80000002), 32'hABCD0000);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_req_ready",  {31'b0, req_ready},  32'd1);
        check("post_reset_resp_valid", {31'b0, resp_valid}, 32'd0);

        // Word load, completion after 3 WAIT cycles.
        t = mk(1'b0, 32'h80000004, 32'h0, 2'd2, 1'b0, 32'hDEADBEEF, 0, 3, 0);
        t.e_rdata = 32'hDEADBEEF; t.e_err = 1'b0; t.e_word = 32'h80000004;
        run_txn(t);

        // Signed and unsigned byte load from the top lane.
        t = mk(1'b0, 32'h80000003, 32'h0, 2'd0, 1'b0, 32'h80123456, 1, 2, 1);
        t.e_rdata = 32'hFFFFFF80; t.e_err = 1'b0;
        run_txn(t);
        t = mk(1'b0, 32'h80000003, 32'h0, 2'd0, 1'b1, 32'h80123456, 0, 1, 0);
        t.e_rdata = 32'h00000080; t.e_err = 1'b0;
        run_txn(t);

        // Half store into the upper lanes.
        t = mk(1'b1, 32'h80000002, 32'h0000ABCD, 2'd1, 1'b0, 32'h12345678, 0, 1, 0);
        t.e_word = 32'h80000000; t.e_mask = 8'h0C; t.e_wdata = 32'hABCD0000;
        t.e_rdata = 32'h0; t.e_err = 1'b0;
        run_txn(t);

        // Misaligned word load and reserved size: error, no memory access.
        t = mk(1'b0, 32'h80000002, 32'h0, 2'd2, 1'b0, 32'h0, 0, 1, 1);
        t.e_access = 1'b0; t.e_err = 1'b1; t.e_rdata = 32'h0;
        run_txn(t);
        t = mk(1'b1, 32'h80000000, 32'h55AA55AA, 2'd3, 1'b0, 32'h0, 0, 1, 0);
        t.e_access = 1'b0; t.e_err = 1'b1; t.e_rdata = 32'h0;
        run_txn(t);

        // mem_ready low 5 cycles, mem_rvalid never: timeout error.
        t = mk(1'b0, 32'h80000010, 32'h0, 2'd2, 1'b0, 32'hCAFEF00D, 5, 1000, 0);
        t.e_err = 1'b1; t.e_rdata = 32'h0; t.e_wait = TB_TIMEOUT;
        run_txn(t);

        // mem_rvalid on the final allowed WAIT cycle succeeds; one later times out.
        t = mk(1'b0, 32'h80000020, 32'h0, 2'd1, 1'b0, 32'h00008001, 0, TB_TIMEOUT, 0);
        t.e_err = 1'b0; t.e_rdata = 32'hFFFF8001;
        run_txn(t);
        t = mk(1'b0, 32'h80000020, 32'h0, 2'd1, 1'b0, 32'h00008001, 0, TB_TIMEOUT + 1, 0);
        t.e_err = 1'b1; t.e_rdata = 32'h0;
        run_txn(t);

        // Reset while in WAIT, late mem_rvalid afterwards must be ignored.
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h80000040; req_size = 2'd2;
        req_unsigned = 1'b0; req_wdata = 32'h0;
        @(negedge clk);
        req_valid = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h11111111;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("late_rvalid_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("late_rvalid_req_ready",  {31'b0, req_ready},  32'd1);
        check("late_rvalid_mem_valid",  {31'b0, mem_valid},  32'd0);
        @(negedge clk);
        check("late_rvalid_still_idle", {31'b0, resp_valid}, 32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 150; n++) begin
            int sel, r_at;
            logic [1:0] size;
            logic [31:0] addr;
            sel  = int'($urandom_range(0, 9));
            size = (sel < 3) ? 2'd0 : (sel < 6) ? 2'd1 : (sel < 9) ? 2'd2 : 2'd3;
            addr = 32'h80000000 | ($urandom & 32'h0000FFFC) | 32'($urandom_range(0, 3));
            sel  = int'($urandom_range(0, 9));
            r_at = (sel == 0) ? TB_TIMEOUT : (sel == 1) ? TB_TIMEOUT + 1
                                           : int'($urandom_range(1, 5));
            t = mk(1'($urandom_range(0, 1)), addr, $urandom, size, 1'($urandom_range(0, 1)),
                   $urandom, int'($urandom_range(0, 3)), r_at, int'($urandom_range(0, 2)));
            run_txn(t);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
